// File: rtl/cache_types.sv
// Shared cache-subsystem types: line geometry and the line buffer FSM state encoding.
package cache_types;

  localparam int LINE_SIZE       = 256;
  localparam int LINE_BEAT_WIDTH = 64;
  localparam int LINE_BEATS      = LINE_SIZE / LINE_BEAT_WIDTH;

  typedef enum logic [2:0] {
    LINE_IDLE,
    WAIT,
    DESERIALIZE,
    DESERIALIZE_DONE,
    SERIALIZE
  } line_buffer_state_t;

endpackage

// File: rtl/cacheline_buffer.sv
// Line buffer between the L2 controller and the burst memory port: assembles fill lines
// from read beats and serializes writeback lines into write beats, one transaction at a time.
module cacheline_buffer
  import cache_types::*;
#(
  parameter int CACHELINE_SIZE = LINE_SIZE,
  parameter int BEAT_WIDTH     = LINE_BEAT_WIDTH,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      line_req_valid,
  input  logic                      line_req_write,
  input  logic [ADDR_WIDTH-1:0]     line_req_addr,
  input  logic [CACHELINE_SIZE-1:0] line_req_wdata,
  output logic                      line_req_ready,
  output logic                      line_resp_valid,
  output logic                      line_resp_write,
  output logic [ADDR_WIDTH-1:0]     line_resp_addr,
  output logic [CACHELINE_SIZE-1:0] line_resp_rdata,
  output logic [ADDR_WIDTH-1:0]     bmem_addr,
  output logic                      bmem_read,
  output logic                      bmem_write,
  output logic [BEAT_WIDTH-1:0]     bmem_wdata,
  input  logic                      bmem_ready,
  input  logic                      bmem_rvalid,
  input  logic [BEAT_WIDTH-1:0]     bmem_rdata
);

  localparam int BEATS  = CACHELINE_SIZE / BEAT_WIDTH;
  localparam int OFFSET = $clog2(CACHELINE_SIZE / 8);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  line_buffer_state_t        state, state_next;
  logic [CNT_W-1:0]          beat_cnt;
  logic [CACHELINE_SIZE-1:0] line_q;
  logic [CACHELINE_SIZE-1:0] line_next;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [BEAT_WIDTH-1:0]     cur_beat;
  logic                      last_beat;

  assign last_beat = (beat_cnt == LAST_BEAT);

  // Slot beat_cnt is both the outgoing write beat and the landing place of a read beat.
  always_comb begin
    cur_beat  = '0;
    line_next = line_q;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_cnt == CNT_W'(i)) begin
        cur_beat = line_q[i*BEAT_WIDTH +: BEAT_WIDTH];
        line_next[i*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LINE_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LINE_IDLE:        if (line_req_valid) state_next = line_req_write ? SERIALIZE : WAIT;
      WAIT:             if (bmem_ready) state_next = DESERIALIZE;
      DESERIALIZE:      if (bmem_rvalid && last_beat) state_next = DESERIALIZE_DONE;
      DESERIALIZE_DONE: state_next = LINE_IDLE;
      SERIALIZE:        if (bmem_ready && last_beat) state_next = LINE_IDLE;
      default:          state_next = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt        <= '0;
      line_q          <= '0;
      addr_q          <= '0;
      line_resp_valid <= 1'b0;
      line_resp_write <= 1'b0;
      line_resp_addr  <= '0;
      line_resp_rdata <= '0;
    end else begin
      line_resp_valid <= 1'b0;
      case (state)
        LINE_IDLE: begin
          if (line_req_valid) begin
            addr_q <= {line_req_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
            line_q <= line_req_wdata;
          end
        end
        DESERIALIZE: begin
          if (bmem_rvalid) begin
            line_q <= line_next;
            if (last_beat) begin
              // Response is captured from line_next so the final beat is included.
              beat_cnt        <= '0;
              line_resp_valid <= 1'b1;
              line_resp_write <= 1'b0;
              line_resp_addr  <= addr_q;
              line_resp_rdata <= line_next;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        SERIALIZE: begin
          if (bmem_ready) begin
            if (last_beat) begin
              beat_cnt        <= '0;
              line_resp_valid <= 1'b1;
              line_resp_write <= 1'b1;
              line_resp_addr  <= addr_q;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign line_req_ready = (state == LINE_IDLE);
  assign bmem_read      = (state == WAIT);
  assign bmem_write     = (state == SERIALIZE);
  assign bmem_wdata     = (state == SERIALIZE) ? cur_beat : '0;
  assign bmem_addr      = (state == WAIT || state == DESERIALIZE || state == SERIALIZE) ? addr_q : '0;

endmodule

// File: tb/tb_cacheline_buffer.sv
// Directed bench for cacheline_buffer: reset abort, fills with stalls and rvalid gaps,
// writeback with ready backpressure, back-to-back request and busy-request rejection.
module tb_cacheline_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         line_req_valid;
  logic         line_req_write;
  logic [31:0]  line_req_addr;
  logic [255:0] line_req_wdata;
  logic         line_req_ready;
  logic         line_resp_valid;
  logic         line_resp_write;
  logic [31:0]  line_resp_addr;
  logic [255:0] line_resp_rdata;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic         bmem_rvalid;
  logic [63:0]  bmem_rdata;

  int checks = 0;
  int errors = 0;

  cacheline_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .line_req_valid  (line_req_valid),
    .line_req_write  (line_req_write),
    .line_req_addr   (line_req_addr),
    .line_req_wdata  (line_req_wdata),
    .line_req_ready  (line_req_ready),
    .line_resp_valid (line_resp_valid),
    .line_resp_write (line_resp_write),
    .line_resp_addr  (line_resp_addr),
    .line_resp_rdata (line_resp_rdata),
    .bmem_addr       (bmem_addr),
    .bmem_read       (bmem_read),
    .bmem_write      (bmem_write),
    .bmem_wdata      (bmem_wdata),
    .bmem_ready      (bmem_ready),
    .bmem_rvalid     (bmem_rvalid),
    .bmem_rdata      (bmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  localparam logic [63:0] A0 = 64'hA0A0_A0A0_A0A0_A0A0, A1 = 64'hA1A1_A1A1_A1A1_A1A1;
  localparam logic [63:0] A2 = 64'hA2A2_A2A2_A2A2_A2A2, A3 = 64'hA3A3_A3A3_A3A3_A3A3;
  localparam logic [63:0] B11 = 64'h1111_1111_1111_1111, B22 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B33 = 64'h3333_3333_3333_3333, B44 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D0 = 64'hD000_0000_0000_00D0, D1 = 64'hD111_1111_1111_11D1;
  localparam logic [63:0] D2 = 64'hD222_2222_2222_22D2, D3 = 64'hD333_3333_3333_33D3;
  localparam logic [63:0] E0 = 64'h0123_4567_89AB_CDEF, E1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] E2 = 64'h5555_AAAA_5555_AAAA, E3 = 64'h0F0F_F0F0_0F0F_F0F0;
  localparam logic [63:0] C0 = 64'hC0C0_0000_0000_C0C0, C1 = 64'hC1C1_0000_0000_C1C1;
  localparam logic [63:0] C2 = 64'hC2C2_0000_0000_C2C2, C3 = 64'hC3C3_0000_0000_C3C3;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0]  rdy_pat;
    logic [63:0] wexp [7];
    logic [6:0]  rv_pat;
    logic [63:0] gap_beats [4];
    int          bi;

    rst_n = 1'b0; line_req_valid = 1'b0; line_req_write = 1'b0; line_req_addr = '0;
    line_req_wdata = '0; bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_rdata = '0;
    #1;
    chk("rst_ready", line_req_ready, 1'b1);
    chk("rst_read", bmem_read, 1'b0);
    chk("rst_write", bmem_write, 1'b0);
    chk("rst_resp_valid", line_resp_valid, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Test 1: reset during writeback beat 2
    line_req_valid = 1'b1; line_req_write = 1'b1; line_req_addr = 32'h0000_4000;
    line_req_wdata = {A3, A2, A1, A0};
    tick();
    line_req_valid = 1'b0; bmem_ready = 1'b1;
    chk("t1_wdata0", bmem_wdata, A0);
    tick();
    chk("t1_wdata1", bmem_wdata, A1);
    tick();
    bmem_ready = 1'b0;
    chk("t1_wdata2", bmem_wdata, A2);
    chk("t1_write_beat2", bmem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t1_write_in_rst", bmem_write, 1'b0);
    chk("t1_resp_in_rst", line_resp_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_ready_after", line_req_ready, 1'b1);
    chk("t1_resp_after", line_resp_valid, 1'b0);

    // Test 2: fill with 3 stall cycles on the read request
    line_req_valid = 1'b1; line_req_write = 1'b0; line_req_addr = 32'h0000_1234;
    tick();
    line_req_valid = 1'b0;
    chk("t2_read_c1", bmem_read, 1'b1);
    chk("t2_addr", bmem_addr, 32'h0000_1220);
    tick();
    chk("t2_read_c2", bmem_read, 1'b1);
    tick();
    chk("t2_read_c3", bmem_read, 1'b1);
    tick();
    bmem_ready = 1'b1;
    chk("t2_read_c4", bmem_read, 1'b1);
    tick();
    bmem_ready = 1'b0;
    chk("t2_read_drop", bmem_read, 1'b0);
    bmem_rvalid = 1'b1; bmem_rdata = B11; tick();
    bmem_rdata = B22; tick();
    bmem_rdata = B33; tick();
    bmem_rdata = B44;
    chk("t2_no_early_resp", line_resp_valid, 1'b0);
    tick();
    bmem_rvalid = 1'b0; bmem_rdata = '0;
    chk("t2_resp_valid", line_resp_valid, 1'b1);
    chk("t2_resp_write", line_resp_write, 1'b0);
    chk("t2_resp_addr", line_resp_addr, 32'h0000_1220);
    chk("t2_resp_rdata", line_resp_rdata, {B44, B33, B22, B11});
    tick();
    chk("t2_pulse_end", line_resp_valid, 1'b0);
    chk("t2_rdata_hold", line_resp_rdata, {B44, B33, B22, B11});
    chk("t2_idle_ready", line_req_ready, 1'b1);

    // Test 3: writeback with ready pattern 1,0,1,0,0,1,1
    line_req_valid = 1'b1; line_req_write = 1'b1; line_req_addr = 32'h0000_8040;
    line_req_wdata = {D3, D2, D1, D0};
    tick();
    line_req_valid = 1'b0; line_req_wdata = '0;
    rdy_pat = 7'b1100101;
    wexp[0] = D0; wexp[1] = D1; wexp[2] = D1; wexp[3] = D2;
    wexp[4] = D2; wexp[5] = D2; wexp[6] = D3;
    for (int i = 0; i < 7; i++) begin
      bmem_ready = rdy_pat[i];
      chk($sformatf("t3_wdata%0d", i), bmem_wdata, wexp[i]);
      chk($sformatf("t3_write%0d", i), bmem_write, 1'b1);
      tick();
    end
    bmem_ready = 1'b0;
    chk("t3_ack_valid", line_resp_valid, 1'b1);
    chk("t3_ack_write", line_resp_write, 1'b1);
    chk("t3_ack_addr", line_resp_addr, 32'h0000_8040);
    chk("t3_write_off", bmem_write, 1'b0);

    // Test 5: new fill on the ack cycle; Test 6: busy request ignored
    chk("t5_ready_on_ack", line_req_ready, 1'b1);
    line_req_valid = 1'b1; line_req_write = 1'b0; line_req_addr = 32'h0000_2000;
    tick();
    line_req_addr = 32'h0000_5000; line_req_write = 1'b1; line_req_wdata = {4{JUNK}};
    chk("t5_read_next", bmem_read, 1'b1);
    chk("t5_addr", bmem_addr, 32'h0000_2000);
    chk("t6_busy_ready", line_req_ready, 1'b0);
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    bmem_rvalid = 1'b1; bmem_rdata = E0; tick();
    chk("t6_addr_held", bmem_addr, 32'h0000_2000);
    bmem_rdata = E1; tick();
    bmem_rdata = E2; tick();
    bmem_rdata = E3; tick();
    bmem_rvalid = 1'b0; line_req_valid = 1'b0;
    chk("t6_resp_valid", line_resp_valid, 1'b1);
    chk("t6_resp_addr", line_resp_addr, 32'h0000_2000);
    chk("t6_resp_rdata", line_resp_rdata, {E3, E2, E1, E0});
    tick();
    chk("t6_back_idle", line_req_ready, 1'b1);

    // Test 4: spurious rvalid in idle/wait, gapped beats in deserialize
    bmem_rvalid = 1'b1; bmem_rdata = JUNK;
    tick();
    line_req_valid = 1'b1; line_req_write = 1'b0; line_req_addr = 32'h0000_301F;
    tick();
    line_req_valid = 1'b0;
    tick();
    bmem_ready = 1'b1;
    chk("t4_read", bmem_read, 1'b1);
    chk("t4_addr", bmem_addr, 32'h0000_3000);
    tick();
    bmem_ready = 1'b0;
    rv_pat = 7'b1011001;
    gap_beats[0] = C0; gap_beats[1] = C1; gap_beats[2] = C2; gap_beats[3] = C3;
    bi = 0;
    for (int i = 0; i < 7; i++) begin
      bmem_rvalid = rv_pat[i];
      bmem_rdata  = rv_pat[i] ? gap_beats[bi] : JUNK;
      if (rv_pat[i]) bi++;
      chk($sformatf("t4_no_resp%0d", i), line_resp_valid, 1'b0);
      tick();
    end
    bmem_rvalid = 1'b0; bmem_rdata = '0;
    chk("t4_resp_valid", line_resp_valid, 1'b1);
    chk("t4_resp_addr", line_resp_addr, 32'h0000_3000);
    chk("t4_resp_rdata", line_resp_rdata, {C3, C2, C1, C0});
    tick();
    chk("t4_pulse_end", line_resp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
